// File: rtl/axis_sync_merge_pkg.sv
// Shared AXIS constants and merge FSM encoding for the pcie-loopback datapath.
package axis_sync_merge_pkg;

  localparam int unsigned AXIS_NARROW_W      = 256;
  localparam int unsigned AXIS_WIDE_W        = 512;
  localparam int unsigned AXIS_NARROW_KEEP_W = AXIS_NARROW_W / 8;
  localparam int unsigned AXIS_WIDE_KEEP_W   = AXIS_WIDE_W / 8;

  // LO: waiting for a lower beat; HI: lower beat held in lo_reg.
  typedef enum logic {
    MERGE_LO = 1'b0,
    MERGE_HI = 1'b1
  } merge_state_e;

endpackage

// File: rtl/axis_sync_merge.sv
// Packs pairs of narrow AXIS beats of one packet into one wide output word.
module axis_sync_merge
  import axis_sync_merge_pkg::*;
#(
  parameter int unsigned S_DATA_WIDTH = AXIS_NARROW_W,
  parameter int unsigned S_KEEP_WIDTH = AXIS_NARROW_KEEP_W
) (
  input  logic                      axis_aclk,
  input  logic                      axis_areset,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic [S_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [S_KEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic                      s_axis_tlast,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [2*S_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [2*S_KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                      m_axis_tlast
);

  merge_state_e            state;
  logic [S_DATA_WIDTH-1:0] lo_data;
  logic [S_KEEP_WIDTH-1:0] lo_keep;
  logic                    accept;

  // Input may advance whenever the output register is empty or draining this cycle.
  assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;

  // Merge FSM and output register; a new word overwrites one leaving on the same edge.
  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      state         <= MERGE_LO;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      if (m_axis_tvalid && m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      if (accept) begin
        case (state)
          MERGE_LO: begin
            if (s_axis_tlast) begin
              m_axis_tvalid <= 1'b1;
              m_axis_tdata  <= {S_DATA_WIDTH'(0), s_axis_tdata};
              m_axis_tkeep  <= {S_KEEP_WIDTH'(0), s_axis_tkeep};
              m_axis_tlast  <= 1'b1;
            end else begin
              lo_data <= s_axis_tdata;
              lo_keep <= s_axis_tkeep;
              state   <= MERGE_HI;
            end
          end
          MERGE_HI: begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= {s_axis_tdata, lo_data};
            m_axis_tkeep  <= {s_axis_tkeep, lo_keep};
            m_axis_tlast  <= s_axis_tlast;
            state         <= MERGE_LO;
          end
          default: state <= MERGE_LO;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_axis_sync_merge.sv
// Self-checking bench for axis_sync_merge: directed cases plus random packets vs a packet-level model.
module tb_axis_sync_merge;

  localparam int unsigned DW = 256;
  localparam int unsigned KW = 32;

  logic            axis_aclk = 1'b0;
  logic            axis_areset;
  logic            s_axis_tvalid;
  logic            s_axis_tready;
  logic [DW-1:0]   s_axis_tdata;
  logic [KW-1:0]   s_axis_tkeep;
  logic            s_axis_tlast;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic [2*DW-1:0] m_axis_tdata;
  logic [2*KW-1:0] m_axis_tkeep;
  logic            m_axis_tlast;

  axis_sync_merge #(.S_DATA_WIDTH(DW), .S_KEEP_WIDTH(KW)) dut (
    .axis_aclk     (axis_aclk),
    .axis_areset   (axis_areset),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast)
  );

  always #5 axis_aclk = ~axis_aclk;

  typedef struct { logic [DW-1:0] d; logic [KW-1:0] k; logic l; } beat_t;
  typedef struct { logic [2*DW-1:0] d; logic [2*KW-1:0] k; logic l; } word_t;

  beat_t pend[$];
  word_t expq[$];

  int vectors     = 0;
  int miscompares = 0;
  int out_cnt     = 0;
  int cyc         = 0;
  bit rand_ready  = 1'b0;

  logic [2*DW-1:0] last_d;
  logic [2*KW-1:0] last_k;
  logic            last_l;
  bit              stall_prev = 1'b0;
  logic [2*DW-1:0] hold_d;
  logic [2*KW-1:0] hold_k;
  logic            hold_l;

  always @(posedge axis_aclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packet-level model: beats of a packet are grouped two at a time, a short tail stands alone.
  task automatic model_accept(input beat_t b);
    pend.push_back(b);
    if (b.l || pend.size() == 2) begin
      word_t w;
      w.d = '0;
      w.k = '0;
      w.l = b.l;
      foreach (pend[i]) begin
        w.d[i*DW +: DW] = pend[i].d;
        w.k[i*KW +: KW] = pend[i].k;
      end
      expq.push_back(w);
      pend.delete();
    end
  endtask

  // Monitor: observes handshakes mid-cycle, feeds the model and scores output words.
  always @(negedge axis_aclk) begin
    beat_t b;
    word_t w;
    if (axis_areset) begin
      expq.delete();
      pend.delete();
      stall_prev = 1'b0;
    end else begin
      check("s_ready_rule", 512'(s_axis_tready), 512'(!m_axis_tvalid || m_axis_tready));
      if (stall_prev) begin
        check("hold_valid", 512'(m_axis_tvalid), 512'(1'b1));
        check("hold_data", m_axis_tdata, hold_d);
        check("hold_keep", 512'(m_axis_tkeep), 512'(hold_k));
        check("hold_last", 512'(m_axis_tlast), 512'(hold_l));
      end
      if (s_axis_tvalid && s_axis_tready) begin
        b.d = s_axis_tdata;
        b.k = s_axis_tkeep;
        b.l = s_axis_tlast;
        model_accept(b);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        vectors++;
        assert (expq.size() != 0) else begin
          miscompares++;
          $error("FAIL unexpected_word observed=%0h expected=none", m_axis_tdata);
        end
        if (expq.size() != 0) begin
          w = expq.pop_front();
          check("word_data", m_axis_tdata, w.d);
          check("word_keep", 512'(m_axis_tkeep), 512'(w.k));
          check("word_last", 512'(m_axis_tlast), 512'(w.l));
        end
        out_cnt++;
        last_d = m_axis_tdata;
        last_k = m_axis_tkeep;
        last_l = m_axis_tlast;
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      hold_d = m_axis_tdata;
      hold_k = m_axis_tkeep;
      hold_l = m_axis_tlast;
    end
  end

  task automatic tick();
    @(posedge axis_aclk);
    #1;
    if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l);
    bit ok = 1'b0;
    int n  = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    while (!ok && n < 500) begin
      @(negedge axis_aclk);
      ok = s_axis_tready;
      tick();
      n++;
    end
    s_axis_tvalid = 1'b0;
    vectors++;
    assert (ok) else begin
      miscompares++;
      $error("FAIL send_timeout observed=stuck expected=accepted data=%0h", d);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() != 0 && n < 2000) begin
      tick();
      n++;
    end
    tick();
    check("drain_empty", 512'(expq.size()), 512'(0));
  endtask

  function automatic logic [DW-1:0] fill(input logic [7:0] b);
    return {32{b}};
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int o0;
    int c0;
    int exp_words;
    int len;
    logic [7:0] v;

    axis_areset   = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b0;
    repeat (2) tick();

    // Reset state
    @(negedge axis_aclk);
    check("rst_m_valid", 512'(m_axis_tvalid), 512'(0));
    check("rst_s_ready", 512'(s_axis_tready), 512'(1));
    check("rst_m_data", m_axis_tdata, 512'(0));
    check("rst_m_keep", 512'(m_axis_tkeep), 512'(0));
    check("rst_m_last", 512'(m_axis_tlast), 512'(0));
    tick();
    axis_areset   = 1'b0;
    m_axis_tready = 1'b1;
    tick();

    // Four-beat packet, full keep
    o0 = out_cnt;
    for (int i = 0; i < 4; i++) begin
      v = 8'hA0 + 8'(i);
      send_beat(fill(v), '1, i == 3);
    end
    drain();
    check("a_words", 512'(out_cnt - o0), 512'(2));
    check("a_data", last_d, {fill(8'hA3), fill(8'hA2)});
    check("a_keep", 512'(last_k), 512'({64{1'b1}}));
    check("a_last", 512'(last_l), 512'(1));

    // Three-beat packet, sparse keep on the tail beat
    o0 = out_cnt;
    send_beat(fill(8'h30), '1, 1'b0);
    send_beat(fill(8'h31), '1, 1'b0);
    send_beat(fill(8'h32), 32'h0000_FFFF, 1'b1);
    drain();
    check("b_words", 512'(out_cnt - o0), 512'(2));
    check("b_data", last_d, {256'(0), fill(8'h32)});
    check("b_keep", 512'(last_k), 512'(64'h0000_0000_0000_FFFF));
    check("b_last", 512'(last_l), 512'(1));

    // Single-beat packet, then a pair to show the lower slot is free again
    o0 = out_cnt;
    send_beat(fill(8'hB0), '1, 1'b1);
    drain();
    check("s_words", 512'(out_cnt - o0), 512'(1));
    check("s_data", last_d, {256'(0), fill(8'hB0)});
    check("s_keep", 512'(last_k), 512'({32'h0, 32'hFFFF_FFFF}));
    check("s_last", 512'(last_l), 512'(1));
    send_beat(fill(8'hF0), '1, 1'b0);
    send_beat(fill(8'hF1), '1, 1'b1);
    drain();
    check("f_data", last_d, {fill(8'hF1), fill(8'hF0)});

    // Backpressure for five cycles with a word pending and input waiting
    o0 = out_cnt;
    m_axis_tready = 1'b0;
    send_beat(fill(8'h60), '1, 1'b0);
    send_beat(fill(8'h61), '1, 1'b0);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = fill(8'h62);
    s_axis_tkeep  = '1;
    s_axis_tlast  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge axis_aclk);
      check("stall_s_ready", 512'(s_axis_tready), 512'(0));
      check("stall_m_data", m_axis_tdata, {fill(8'h61), fill(8'h60)});
      tick();
    end
    m_axis_tready = 1'b1;
    send_beat(fill(8'h62), '1, 1'b0);
    send_beat(fill(8'h63), '1, 1'b1);
    drain();
    check("stall_words", 512'(out_cnt - o0), 512'(2));
    check("stall_data", last_d, {fill(8'h63), fill(8'h62)});

    // Full rate: back-to-back beats, one word per two beats
    o0 = out_cnt;
    c0 = cyc;
    for (int i = 0; i < 16; i++) begin
      v = 8'h40 + 8'(i);
      send_beat(fill(v), '1, i == 15);
    end
    check("rate_cycles", 512'(cyc - c0), 512'(16));
    drain();
    check("rate_words", 512'(out_cnt - o0), 512'(8));

    // Reset with a pending word, then reset mid-packet
    m_axis_tready = 1'b0;
    send_beat(fill(8'hE0), '1, 1'b1);
    axis_areset = 1'b1;
    tick();
    axis_areset = 1'b0;
    @(negedge axis_aclk);
    check("rst2_m_valid", 512'(m_axis_tvalid), 512'(0));
    check("rst2_s_ready", 512'(s_axis_tready), 512'(1));
    check("rst2_m_data", m_axis_tdata, 512'(0));
    tick();
    m_axis_tready = 1'b1;
    o0 = out_cnt;
    send_beat(fill(8'h50), '1, 1'b0);
    axis_areset = 1'b1;
    tick();
    axis_areset = 1'b0;
    send_beat(fill(8'hC0), '1, 1'b0);
    send_beat(fill(8'hC1), '1, 1'b1);
    drain();
    check("rst_words", 512'(out_cnt - o0), 512'(1));
    check("rst_data", last_d, {fill(8'hC1), fill(8'hC0)});

    // Random packets with random valid gaps and random ready
    o0 = out_cnt;
    exp_words = 0;
    rand_ready = 1'b1;
    for (int p = 0; p < 1000; p++) begin
      len = int'($urandom_range(1, 6));
      exp_words += (len + 1) / 2;
      for (int b = 0; b < len; b++) begin
        repeat ($urandom_range(0, 2)) tick();
        send_beat(rand_data(), $urandom, b == len - 1);
      end
    end
    rand_ready = 1'b0;
    m_axis_tready = 1'b1;
    drain();
    check("rand_words", 512'(out_cnt - o0), 512'(exp_words));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axis_sync_merge.md
AXIS_SYNC_MERGE -- requirements
Module: axis_sync_merge

Interface
REQ-001 The block SHALL have parameter S_DATA_WIDTH, default 256: input beat width in bits; the output width is 2*S_DATA_WIDTH.
REQ-002 The block SHALL have parameter S_KEEP_WIDTH, default 32: input tkeep width, equal to S_DATA_WIDTH/8; output tkeep is 2*S_KEEP_WIDTH.
REQ-003 The block SHALL have port axis_aclk, input, 1 bit: the single clock for both interfaces.
REQ-004 The block SHALL have port axis_areset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port s_axis_tvalid, input, 1 bit: input beat valid.
REQ-006 The block SHALL have port s_axis_tready, output, 1 bit: input beat accepted.
REQ-007 The block SHALL have port s_axis_tdata, input, 256 bits: input data.
REQ-008 The block SHALL have port s_axis_tkeep, input, 32 bits: input byte enables.
REQ-009 The block SHALL have port s_axis_tlast, input, 1 bit: last input beat of the packet.
REQ-010 The block SHALL have port m_axis_tvalid, output, 1 bit: output word valid.
REQ-011 The block SHALL have port m_axis_tready, input, 1 bit: downstream accepts the word.
REQ-012 The block SHALL have port m_axis_tdata, output, 512 bits: merged data.
REQ-013 The block SHALL have port m_axis_tkeep, output, 64 bits: merged byte enables.
REQ-014 The block SHALL have port m_axis_tlast, output, 1 bit: last output word of the packet.

Function
REQ-015 The block SHALL pack two consecutive accepted input beats of one packet into one output word: the first beat goes to bits [255:0] and keep [31:0], the second beat to bits [511:256] and keep [63:32].
REQ-016 The block SHALL have a two-state FSM: LO waits for a lower beat; HI holds a lower beat in lo_reg.
REQ-017 On an accepted beat in LO with tlast=0, the block SHALL store the beat in lo_reg and go to HI; no output is produced.
REQ-018 On an accepted beat in LO with tlast=1, the block SHALL load the output register with upper data=0, upper keep=0 and tlast=1, and stay in LO.
REQ-019 On an accepted beat in HI, the block SHALL load the output register with {beat, lo_reg}, with tlast equal to the beat's tlast, and go to LO.
REQ-020 The output register SHALL drive m_axis_* directly, with no combinational path from s_axis_* to m_axis_*.
REQ-021 Latency SHALL be 1 cycle from the accepted beat that completes a word to m_axis_tvalid=1.
REQ-022 The block SHALL drive s_axis_tready = !m_axis_tvalid || m_axis_tready in both states; it SHALL NOT depend on s_axis_tvalid or s_axis_tlast.
REQ-023 When an output handshake and a word completion occur in the same cycle, the block SHALL load the new word and keep m_axis_tvalid=1, giving one output word every two input beats at full rate.
REQ-024 When an output handshake occurs with no completion, the block SHALL clear m_axis_tvalid the next cycle.
REQ-025 While m_axis_tvalid=1 and m_axis_tready=0, the block SHALL hold all m_axis_* outputs stable.
REQ-026 The block SHALL pass input tkeep through unmodified, with no validation and no repacking of sparse keep.
REQ-027 A single-beat packet SHALL produce exactly one output word with keep[63:32]=0.

Reset
REQ-028 While axis_areset=1 on a clock edge, the block SHALL set state=LO, m_axis_tvalid=0 and lo_reg contents to don't-care; s_axis_tready SHALL then read 1.
REQ-029 On reset in the middle of a packet, the block SHALL discard any held lower beat and pending output word; the first beat after reset is treated as a lower beat.
REQ-030 The block SHALL reset m_axis_tdata, m_axis_tkeep and m_axis_tlast to 0.

Structure
REQ-031 The constants AXIS_NARROW_W=256, AXIS_WIDE_W=512 and the FSM state encoding SHALL live in the shared pcie-loopback AXIS package.
REQ-032 The block SHALL be a single module with no sub-modules and no vendor FIFO IP.

Verification
REQ-033 The bench SHALL drive a 4-beat packet (0xA0..,0xA1..,0xA2..,0xA3..), keep all-ones, with m_ready=1; two words {A1,A0} and {A3,A2} SHALL appear with keep all-ones and tlast only on the second word.
REQ-034 The bench SHALL drive a 3-beat packet whose last keep is 0x0000FFFF; the second word SHALL carry lower half = beat 3, keep=0x00000000_0000FFFF and tlast=1.
REQ-035 The bench SHALL drive a 1-beat packet B0 with tlast=1; one word SHALL appear with upper=0, keep[63:32]=0, tlast=1, and the FSM SHALL remain in LO.
REQ-036 The bench SHALL hold m_ready=0 for 5 cycles with a word pending while streaming input; s_ready SHALL fall, the output SHALL stay stable, and there SHALL be no loss or duplication after release.
REQ-037 The bench SHALL pulse axis_areset after beat 1 of a 4-beat packet, then send packet C0..C1; only {C1,C0} SHALL be output.
REQ-038 The bench SHALL stream 1000 random packets with random valid/ready; a scoreboard SHALL match the expected merged stream and show full-rate throughput when ready=valid=1.
